ifetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined ARM core; the producer feeding the decode stage its instruction and PC+8.
- Keeps the fetch PC, issues in-order word requests to instruction memory over a valid/ready request channel, and collects responses into a small prefetch FIFO.
- Presents the FIFO head to decode with a valid/ready handshake.
- Branch/PC-write redirects flush the FIFO and discard every in-flight response.

---
 rtl/ifetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_ifetch_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
//   Instruction-fetch stage. It keeps the fetch PC, issues in-order word
//   requests to instruction memory over a valid/ready channel, collects the
//   responses in a small prefetch FIFO, and presents the FIFO head to decode
//   with a valid/ready handshake. A redirect (taken branch / write to R15)
//   flushes the FIFO and marks every in-flight response for discard.
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-high reset, clears all state
//   imem_req_valid   out  request valid (combinational)
//   imem_req_addr    out  word-aligned fetch address (fetch PC)
//   imem_req_ready   in   memory accepts the request this cycle
//   imem_resp_valid  in   response beat, in request order
//   imem_resp_data   in   instruction word of the response beat
//   redirect_valid   in   PC write; highest priority
//   redirect_pc      in   new fetch PC, bits [1:0] ignored
//   dec_ready        in   decode consumes the head this cycle
//   InstrF           out  instruction at the FIFO head (registered)
//   PCPlus8          out  address of InstrF + 8 (registered)
//   InstrValidF      out  InstrF/PCPlus8 valid (registered)
// -----------------------------------------------------------------------------
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        dec_ready,
   output logic [31:0] InstrF,
   output logic [31:0] PCPlus8,
   output logic        InstrValidF
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   // architectural state
   logic [31:0]   fpc_r;
   logic [31:0]   hpc_r;
   logic [CW-1:0] pending_r;
   logic [CW-1:0] drop_r;
   logic [CW-1:0] count_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [31:0]   mem_r [DEPTH];

   // registered decode-side outputs
   logic [31:0]   instr_r;
   logic [31:0]   pc_plus8_r;
   logic          valid_r;

   // next-state and control
   logic [31:0]   fpc_n_s;
   logic [31:0]   hpc_n_s;
   logic [CW-1:0] pending_n_s;
   logic [CW-1:0] drop_n_s;
   logic [CW-1:0] count_n_s;
   logic [AW-1:0] rd_ptr_n_s;
   logic [AW-1:0] wr_ptr_n_s;
   logic [31:0]   head_n_s;
   logic [CW:0]   in_use_s;
   logic          resp_s;
   logic          pop_s;
   logic          push_s;
   logic          req_valid_s;
   logic          accept_s;

   // Request credit, handshake qualification and FIFO push/pop decisions.
   // A slot freed by this cycle's pop is counted as free, so with a
   // single-cycle memory the stage sustains one request per cycle while the
   // FIFO plus in-flight requests still never exceed DEPTH after the edge.
   always_comb begin
      resp_s      = imem_resp_valid && (pending_r != {CW{1'b0}});
      pop_s       = valid_r && dec_ready;
      in_use_s    = (CW+1)'(pending_r) + (CW+1)'(count_r) - (CW+1)'(pop_s);
      req_valid_s = !redirect_valid && (in_use_s < DEPTH_W);
      accept_s    = req_valid_s && imem_req_ready;
      push_s      = resp_s && !redirect_valid && (drop_r == {CW{1'b0}});
   end

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = fpc_r;
   assign InstrF         = instr_r;
   assign PCPlus8        = pc_plus8_r;
   assign InstrValidF    = valid_r;

   // Next-state for PCs, counters and FIFO pointers; redirect overrides all.
   always_comb begin
      fpc_n_s     = fpc_r;
      hpc_n_s     = hpc_r;
      pending_n_s = pending_r;
      drop_n_s    = drop_r;
      count_n_s   = count_r;
      rd_ptr_n_s  = rd_ptr_r;
      wr_ptr_n_s  = wr_ptr_r;
      if (redirect_valid) begin
         fpc_n_s     = {redirect_pc[31:2], 2'b00};
         hpc_n_s     = {redirect_pc[31:2], 2'b00};
         // every request still outstanding after this cycle is stale
         pending_n_s = pending_r - CW'(resp_s);
         drop_n_s    = pending_r - CW'(resp_s);
         count_n_s   = {CW{1'b0}};
         rd_ptr_n_s  = {AW{1'b0}};
         wr_ptr_n_s  = {AW{1'b0}};
      end else begin
         if (accept_s) begin
            fpc_n_s = fpc_r + 32'd4;
         end else begin
            fpc_n_s = fpc_r;
         end
         pending_n_s = pending_r + CW'(accept_s) - CW'(resp_s);
         if (resp_s && (drop_r != {CW{1'b0}})) begin
            drop_n_s = drop_r - {{(CW-1){1'b0}}, 1'b1};
         end else begin
            drop_n_s = drop_r;
         end
         if (pop_s) begin
            hpc_n_s    = hpc_r + 32'd4;
            rd_ptr_n_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end else begin
            hpc_n_s    = hpc_r;
            rd_ptr_n_s = rd_ptr_r;
         end
         if (push_s) begin
            wr_ptr_n_s = wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_n_s = wr_ptr_r;
         end
         count_n_s = count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // Head after the edge: the word being written now if it lands in the
   // head slot (FIFO was empty or is draining to it), otherwise storage.
   always_comb begin
      if (push_s && (rd_ptr_n_s == wr_ptr_r)) begin
         head_n_s = imem_resp_data;
      end else begin
         head_n_s = mem_r[rd_ptr_n_s];
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fpc_r      <= RESET_PC;
         hpc_r      <= RESET_PC;
         pending_r  <= {CW{1'b0}};
         drop_r     <= {CW{1'b0}};
         count_r    <= {CW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         instr_r    <= 32'h0000_0000;
         pc_plus8_r <= 32'h0000_0000;
         valid_r    <= 1'b0;
      end else begin
         fpc_r      <= fpc_n_s;
         hpc_r      <= hpc_n_s;
         pending_r  <= pending_n_s;
         drop_r     <= drop_n_s;
         count_r    <= count_n_s;
         rd_ptr_r   <= rd_ptr_n_s;
         wr_ptr_r   <= wr_ptr_n_s;
         instr_r    <= head_n_s;
         pc_plus8_r <= hpc_n_s + 32'd8;
         valid_r    <= (count_n_s != {CW{1'b0}});
      end
   end

   // Prefetch FIFO storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'h0000_0000;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= imem_resp_data;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_ready;
   logic [31:0] InstrF;
   logic [31:0] PCPlus8;
   logic        InstrValidF;

   int vectors     = 0;
   int miscompares = 0;

   // memory model configuration and state
   int          lat_min = 1;
   int          lat_max = 1;
   int          cyc;
   logic [31:0] q_addr[$];
   int          q_due[$];

   ifetch_unit #(.RESET_PC(32'h0000_8000), .DEPTH(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .dec_ready       (dec_ready),
      .InstrF          (InstrF),
      .PCPlus8         (PCPlus8),
      .InstrValidF     (InstrValidF)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
   endfunction

   // In-order instruction memory with configurable latency (>= 1 cycle).
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q_addr.delete();
         q_due.delete();
         imem_resp_valid <= 1'b0;
         imem_resp_data  <= 32'h0;
         cyc             <= 0;
      end else begin
         cyc <= cyc + 1;
         if (imem_resp_valid) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)) - 1);
         end
         if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_resp_valid <= 1'b1;
            imem_resp_data  <= mem_word(q_addr[0]);
         end else begin
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= 32'h0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          delivered;
      int          cycles;
      logic [31:0] exp_pc8;

      reset          = 1'b1;
      imem_req_ready = 1'b1;
      dec_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(InstrValidF), 32'd0);
      chk("rst_instr", InstrF, 32'h0);
      chk("rst_pc8",   PCPlus8, 32'h0);

      // release: requests one per cycle from RESET_PC
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
      chk("c1_req_addr",  imem_req_addr, 32'h0000_8000);
      chk("c1_valid",     32'(InstrValidF), 32'd0);
      step();
      chk("c2_req_addr",  imem_req_addr, 32'h0000_8004);
      chk("c2_valid",     32'(InstrValidF), 32'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("stream_valid", 32'(InstrValidF), 32'd1);
         chk("stream_pc8",   PCPlus8, 32'h0000_8008 + 32'(4*i));
         chk("stream_instr", InstrF, mem_word(32'h0000_8000 + 32'(4*i)));
         chk("stream_req",   imem_req_addr, 32'h0000_8008 + 32'(4*i));
         step();
      end

      // decode stall for 5 cycles: outputs frozen, FIFO fills, no requests
      dec_ready = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", 32'(InstrValidF), 32'd1);
         chk("stall_pc8",   PCPlus8, 32'h0000_8014);
         chk("stall_instr", InstrF, mem_word(32'h0000_800C));
         chk("stall_req",   32'(imem_req_valid), 32'd0);
         step();
      end
      dec_ready = 1'b1;
      #1;
      chk("resume_req_valid", 32'(imem_req_valid), 32'd1);
      chk("resume_req_addr",  imem_req_addr, 32'h0000_8014);
      for (int i = 0; i < 4; i++) begin
         chk("resume_valid", 32'(InstrValidF), 32'd1);
         chk("resume_pc8",   PCPlus8, 32'h0000_8014 + 32'(4*i));
         chk("resume_instr", InstrF, mem_word(32'h0000_800C + 32'(4*i)));
         step();
      end

      // drain with memory stalled, then 3-cycle memory
      imem_req_ready = 1'b0;
      lat_min = 3;
      lat_max = 3;
      repeat (3) step();
      chk("drain_valid", 32'(InstrValidF), 32'd0);
      chk("drain_pc8",   PCPlus8, 32'h0000_802C);
      imem_req_ready = 1'b1;
      #1;
      chk("fl_req_addr0", imem_req_addr, 32'h0000_8024);
      step();
      chk("fl_req_addr1", imem_req_addr, 32'h0000_8028);
      step();
      chk("fl_credit_full", 32'(imem_req_valid), 32'd0);

      // redirect with two requests in flight; both responses dropped
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      #1;
      chk("rd1_no_req", 32'(imem_req_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      #1;
      chk("rd1_c1_valid", 32'(InstrValidF), 32'd0);
      chk("rd1_c1_req",   32'(imem_req_valid), 32'd0);
      step();
      chk("rd1_c2_valid",    32'(InstrValidF), 32'd0);
      chk("rd1_c2_req",      32'(imem_req_valid), 32'd1);
      chk("rd1_c2_req_addr", imem_req_addr, 32'h0000_0100);
      step();
      for (int k = 0; k < 3; k++) begin
         chk("rd1_wait_valid", 32'(InstrValidF), 32'd0);
         step();
      end
      chk("rd1_first_valid", 32'(InstrValidF), 32'd1);
      chk("rd1_first_pc8",   PCPlus8, 32'h0000_0108);
      chk("rd1_first_instr", InstrF, mem_word(32'h0000_0100));

      // redirect coincident with a response beat and an active pop
      chk("rd2_beat_present", 32'(imem_resp_valid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      #1;
      chk("rd2_no_req", 32'(imem_req_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      #1;
      chk("rd2_flushed",  32'(InstrValidF), 32'd0);
      chk("rd2_pc8",      PCPlus8, 32'h0000_0208);
      chk("rd2_req",      32'(imem_req_valid), 32'd1);
      chk("rd2_req_addr", imem_req_addr, 32'h0000_0200);
      step();
      for (int k = 0; k < 3; k++) begin
         chk("rd2_wait_valid", 32'(InstrValidF), 32'd0);
         step();
      end
      chk("rd2_first_valid", 32'(InstrValidF), 32'd1);
      chk("rd2_first_pc8",   PCPlus8, 32'h0000_0208);
      chk("rd2_first_instr", InstrF, mem_word(32'h0000_0200));

      // random ready / latency / decode stalls: sequential delivery
      lat_min   = 1;
      lat_max   = 4;
      delivered = 0;
      cycles    = 0;
      exp_pc8   = 32'h0000_0208;
      while (delivered < 200 && cycles < 4000) begin
         imem_req_ready = 1'($urandom_range(1, 0));
         dec_ready      = ($urandom_range(3, 0) != 0);
         #1;
         chk("rand_pending_le2", (q_addr.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
         if (InstrValidF && dec_ready) begin
            chk("rand_pc8",   PCPlus8, exp_pc8);
            chk("rand_instr", InstrF, mem_word(exp_pc8 - 32'd8));
            exp_pc8 = exp_pc8 + 32'd4;
            delivered++;
         end
         step();
         cycles++;
      end
      if (delivered < 200) begin
         chk("rand_timeout", 32'(delivered), 32'd200);
      end

      // async reset between clock edges
      #3;
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(InstrValidF), 32'd0);
      chk("arst_instr", InstrF, 32'h0);
      chk("arst_pc8",   PCPlus8, 32'h0);
      @(posedge clk);
      @(negedge clk);
      imem_req_ready = 1'b1;
      dec_ready      = 1'b1;
      lat_min        = 1;
      lat_max        = 1;
      reset          = 1'b0;
      #1;
      chk("arst_req_valid", 32'(imem_req_valid), 32'd1);
      chk("arst_req_addr",  imem_req_addr, 32'h0000_8000);
      step();
      step();
      chk("arst_first_valid", 32'(InstrValidF), 32'd1);
      chk("arst_first_pc8",   PCPlus8, 32'h0000_8008);
      chk("arst_first_instr", InstrF, mem_word(32'h0000_8000));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
